// File: rtl/branch_issue_queue_if.sv
// ---------------------------------------------------------------------------
// branch_issue_queue_if
//  Bundles the dispatch, flag write-back and branch-ALU issue signals of the
//  branch issue queue. Clock and reset are kept as plain ports on the queue.
//  Ports (as seen by the queue, modport slave):
//   iFREE_RESTART              in   sync pipeline flush
//   iDISP_*                    in   dispatch request and op fields
//   oDISP_FULL                 out  queue cannot accept
//   iFLAG_WB_VALID/TAG/DATA    in   flag write-back bus
//   oEX_BRANCH_*               out  registered issue strobe and op fields
//   iEX_BRANCH_LOCK            in   ALU redirect lock
//   oCOUNT                     out  occupied entries
//  modport master is the driving side (dispatch / ALU / testbench).
// ---------------------------------------------------------------------------
interface branch_issue_queue_if #(
  parameter int PTR_W = 2
);
  logic             iFREE_RESTART;
  logic             iDISP_VALID;
  logic [5:0]       iDISP_COMMIT_TAG;
  logic [4:0]       iDISP_CMD;
  logic [3:0]       iDISP_CC;
  logic [31:0]      iDISP_SOURCE;
  logic [31:0]      iDISP_PC;
  logic             iDISP_FLAG_VALID;
  logic [4:0]       iDISP_FLAG;
  logic [5:0]       iDISP_FLAG_TAG;
  logic             oDISP_FULL;
  logic             iFLAG_WB_VALID;
  logic [5:0]       iFLAG_WB_TAG;
  logic [4:0]       iFLAG_WB_DATA;
  logic             oEX_BRANCH_VALID;
  logic [5:0]       oEX_BRANCH_COMMIT_TAG;
  logic [4:0]       oEX_BRANCH_CMD;
  logic [3:0]       oEX_BRANCH_CC;
  logic [4:0]       oEX_BRANCH_FLAG;
  logic [31:0]      oEX_BRANCH_SOURCE;
  logic [31:0]      oEX_BRANCH_PC;
  logic             iEX_BRANCH_LOCK;
  logic [PTR_W:0]   oCOUNT;

  modport master (
    output iFREE_RESTART, iDISP_VALID, iDISP_COMMIT_TAG, iDISP_CMD, iDISP_CC,
           iDISP_SOURCE, iDISP_PC, iDISP_FLAG_VALID, iDISP_FLAG, iDISP_FLAG_TAG,
           iFLAG_WB_VALID, iFLAG_WB_TAG, iFLAG_WB_DATA, iEX_BRANCH_LOCK,
    input  oDISP_FULL, oEX_BRANCH_VALID, oEX_BRANCH_COMMIT_TAG, oEX_BRANCH_CMD,
           oEX_BRANCH_CC, oEX_BRANCH_FLAG, oEX_BRANCH_SOURCE, oEX_BRANCH_PC, oCOUNT
  );

  modport slave (
    input  iFREE_RESTART, iDISP_VALID, iDISP_COMMIT_TAG, iDISP_CMD, iDISP_CC,
           iDISP_SOURCE, iDISP_PC, iDISP_FLAG_VALID, iDISP_FLAG, iDISP_FLAG_TAG,
           iFLAG_WB_VALID, iFLAG_WB_TAG, iFLAG_WB_DATA, iEX_BRANCH_LOCK,
    output oDISP_FULL, oEX_BRANCH_VALID, oEX_BRANCH_COMMIT_TAG, oEX_BRANCH_CMD,
           oEX_BRANCH_CC, oEX_BRANCH_FLAG, oEX_BRANCH_SOURCE, oEX_BRANCH_PC, oCOUNT
  );
endinterface

// File: rtl/branch_issue_queue.sv
// ---------------------------------------------------------------------------
// branch_issue_queue
//  In-order issue queue for the branch execution unit. Buffers dispatched
//  branch ops, waits for their condition flags (captured from the flag
//  write-back bus), then issues the head op to the branch ALU, one per cycle.
//  Ports:
//   iCLOCK   in  clock
//   iRESET   in  async reset, active-high
//   bus      slave modport of branch_issue_queue_if (dispatch, flag WB,
//            issue, lock, full, count)
//
//  state  | meaning
//  RUN    | normal operation: dispatch accepted when not full, head issues
//  LOCKED | ALU took a redirect: no issue, no dispatch; left only by restart
// ---------------------------------------------------------------------------
module branch_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic iCLOCK,
  input logic iRESET,
  branch_issue_queue_if.slave bus
);

  localparam logic [0:0]     L_STATE_RUN    = 1'b0;
  localparam logic [0:0]     L_STATE_LOCKED = 1'b1;
  localparam logic [PTR_W:0] L_DEPTH        = (PTR_W+1)'(DEPTH);

  logic [0:0]       bState;
  logic [PTR_W-1:0] bWrPtr;
  logic [PTR_W-1:0] bRdPtr;
  logic [PTR_W:0]   bCount;

  logic             bEntValid   [DEPTH];
  logic             bEntFlagRdy [DEPTH];
  logic [4:0]       bEntFlag    [DEPTH];
  logic [5:0]       bEntFlagTag [DEPTH];
  logic [5:0]       bEntTag     [DEPTH];
  logic [4:0]       bEntCmd     [DEPTH];
  logic [3:0]       bEntCc      [DEPTH];
  logic [31:0]      bEntSource  [DEPTH];
  logic [31:0]      bEntPc      [DEPTH];

  logic             bExValid;
  logic [5:0]       bExTag;
  logic [4:0]       bExCmd;
  logic [3:0]       bExCc;
  logic [4:0]       bExFlag;
  logic [31:0]      bExSource;
  logic [31:0]      bExPc;

  logic             full;
  logic             dispAccept;
  logic             issueGo;
  logic             dispWake;

  assign full       = (bCount == L_DEPTH) || (bState == L_STATE_LOCKED);
  assign dispAccept = bus.iDISP_VALID && !full;
  // Head readiness comes from registered flag_rdy, so a wakeup at this edge
  // can only lead to an issue at the next edge.
  assign issueGo    = bEntValid[bRdPtr] && bEntFlagRdy[bRdPtr] &&
                      (bState == L_STATE_RUN) && !bus.iEX_BRANCH_LOCK;
  // An op arriving with unresolved flags can still catch a same-cycle write-back.
  assign dispWake   = !bus.iDISP_FLAG_VALID && bus.iFLAG_WB_VALID &&
                      (bus.iFLAG_WB_TAG == bus.iDISP_FLAG_TAG);

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      bState    <= L_STATE_RUN;
      bWrPtr    <= '0;
      bRdPtr    <= '0;
      bCount    <= '0;
      bExValid  <= 1'b0;
      bExTag    <= '0;
      bExCmd    <= '0;
      bExCc     <= '0;
      bExFlag   <= '0;
      bExSource <= '0;
      bExPc     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bEntValid[i]   <= 1'b0;
        bEntFlagRdy[i] <= 1'b0;
        bEntFlag[i]    <= '0;
        bEntFlagTag[i] <= '0;
        bEntTag[i]     <= '0;
        bEntCmd[i]     <= '0;
        bEntCc[i]      <= '0;
        bEntSource[i]  <= '0;
        bEntPc[i]      <= '0;
      end
    end else if (bus.iFREE_RESTART) begin
      bState    <= L_STATE_RUN;
      bWrPtr    <= '0;
      bRdPtr    <= '0;
      bCount    <= '0;
      bExValid  <= 1'b0;
      bExTag    <= '0;
      bExCmd    <= '0;
      bExCc     <= '0;
      bExFlag   <= '0;
      bExSource <= '0;
      bExPc     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bEntValid[i]   <= 1'b0;
        bEntFlagRdy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.iFLAG_WB_VALID && bEntValid[i] && !bEntFlagRdy[i] &&
            (bEntFlagTag[i] == bus.iFLAG_WB_TAG)) begin
          bEntFlagRdy[i] <= 1'b1;
          bEntFlag[i]    <= bus.iFLAG_WB_DATA;
        end
      end

      // The write slot is never a valid entry when dispatch is accepted, so
      // this cannot collide with the wakeup loop above or the pop below.
      if (dispAccept) begin
        bEntValid[bWrPtr]   <= 1'b1;
        bEntFlagRdy[bWrPtr] <= bus.iDISP_FLAG_VALID || dispWake;
        bEntFlag[bWrPtr]    <= bus.iDISP_FLAG_VALID ? bus.iDISP_FLAG : bus.iFLAG_WB_DATA;
        bEntFlagTag[bWrPtr] <= bus.iDISP_FLAG_TAG;
        bEntTag[bWrPtr]     <= bus.iDISP_COMMIT_TAG;
        bEntCmd[bWrPtr]     <= bus.iDISP_CMD;
        bEntCc[bWrPtr]      <= bus.iDISP_CC;
        bEntSource[bWrPtr]  <= bus.iDISP_SOURCE;
        bEntPc[bWrPtr]      <= bus.iDISP_PC;
        bWrPtr              <= bWrPtr + PTR_W'(1);
      end

      bExValid <= issueGo;
      if (issueGo) begin
        bEntValid[bRdPtr] <= 1'b0;
        bRdPtr            <= bRdPtr + PTR_W'(1);
        bExTag            <= bEntTag[bRdPtr];
        bExCmd            <= bEntCmd[bRdPtr];
        bExCc             <= bEntCc[bRdPtr];
        bExFlag           <= bEntFlag[bRdPtr];
        bExSource         <= bEntSource[bRdPtr];
        bExPc             <= bEntPc[bRdPtr];
      end

      case ({dispAccept, issueGo})
        2'b10:   bCount <= bCount + (PTR_W+1)'(1);
        2'b01:   bCount <= bCount - (PTR_W+1)'(1);
        default: bCount <= bCount;
      endcase

      if ((bState == L_STATE_RUN) && bus.iEX_BRANCH_LOCK) begin
        bState <= L_STATE_LOCKED;
      end
    end
  end

  assign bus.oDISP_FULL            = full;
  assign bus.oCOUNT                = bCount;
  assign bus.oEX_BRANCH_VALID      = bExValid;
  assign bus.oEX_BRANCH_COMMIT_TAG = bExTag;
  assign bus.oEX_BRANCH_CMD        = bExCmd;
  assign bus.oEX_BRANCH_CC         = bExCc;
  assign bus.oEX_BRANCH_FLAG       = bExFlag;
  assign bus.oEX_BRANCH_SOURCE     = bExSource;
  assign bus.oEX_BRANCH_PC         = bExPc;

endmodule
